linear_network_collect_seq: RTL and testbench

Pipelined linear collection network: the return-direction counterpart of the linear multicast chain. Each of NUM_NODE nodes can inject one word into a one-slot-per-stage register chain that carries words hop by hop toward a single sink port at node 0. The chain uses valid/ready handshakes on every node port and on the sink, with per-stage fair arbitration between through traffic and local injection.

---
 rtl/linear_network_pkg.sv | 18 +
 rtl/linear_collect_stage.sv | 112 +++++++++++
 rtl/linear_network_collect_seq.sv | 88 ++++++++
 tb/tb_linear_network_collect_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_network_pkg.sv
// Shared constants and helpers for the linear network family (multicast and collect chains).
package linear_network_pkg;

    // Filler bit replicated to payload width on idle or reset data paths.
    localparam logic DUMMY_DATA = 1'b0;

    function automatic int id_width(input int n);
        int w;
        w = 1;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/linear_collect_stage.sv
// One slot of the collection chain: slot register, 2:1 fair arbiter (through vs local), adv/take/ready.
// Source-tag register is built only when LINEAR_NETWORK_SRC_ID_EN is defined.
module linear_collect_stage
    import linear_network_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int STAGE_ID   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  loc_valid,
    input  logic [DATA_WIDTH-1:0] loc_data,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic [ID_WIDTH-1:0]   up_id,
    input  logic                  dn_take,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ID_WIDTH-1:0]   id,
    output logic                  up_take,
    output logic                  loc_ready
);

    localparam logic [ID_WIDTH-1:0] LOC_ID = ID_WIDTH'(STAGE_ID);

    logic                  valid_r;
    logic                  prio_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  adv_s;
    logic                  loc_req_s;
    logic                  contend_s;
    logic                  grant_up_s;
    logic                  grant_loc_s;

    // Slot may load when empty or when its word leaves this cycle; prio_r breaks ties.
    always_comb begin
        adv_s       = ~valid_r | dn_take;
        loc_req_s   = en & loc_valid;
        contend_s   = up_valid & loc_req_s;
        grant_up_s  = 1'b0;
        grant_loc_s = 1'b0;
        if (adv_s) begin
            if (contend_s) begin
                grant_up_s  = ~prio_r;
                grant_loc_s = prio_r;
            end else begin
                grant_up_s  = up_valid;
                grant_loc_s = loc_req_s;
            end
        end else begin
            grant_up_s  = 1'b0;
            grant_loc_s = 1'b0;
        end
    end

    // Slot and priority state; priority flips only on a granted contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{DUMMY_DATA}};
            prio_r  <= 1'b0;
        end else begin
            if (grant_up_s) begin
                valid_r <= 1'b1;
                data_r  <= up_data;
            end else if (grant_loc_s) begin
                valid_r <= 1'b1;
                data_r  <= loc_data;
            end else if (dn_take) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            if (adv_s & contend_s) begin
                prio_r <= ~prio_r;
            end else begin
                prio_r <= prio_r;
            end
        end
    end

`ifdef LINEAR_NETWORK_SRC_ID_EN
    logic [ID_WIDTH-1:0] id_r;

    // Tag follows the word: own index for local loads, upstream tag otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r <= {ID_WIDTH{1'b0}};
        end else if (grant_up_s) begin
            id_r <= up_id;
        end else if (grant_loc_s) begin
            id_r <= LOC_ID;
        end else begin
            id_r <= id_r;
        end
    end

    assign id = id_r;
`else
    logic unused_id_s;
    assign unused_id_s = ^{up_id, LOC_ID};
    assign id          = {ID_WIDTH{1'b0}};
`endif

    assign valid     = valid_r;
    assign data      = data_r;
    assign up_take   = grant_up_s;
    assign loc_ready = grant_loc_s;

endmodule

// File: rtl/linear_network_collect_seq.sv
// Pipelined linear collection chain: NUM_NODE injecting nodes feed a register chain draining to one sink.
// Optional source tagging is enabled by defining LINEAR_NETWORK_SRC_ID_EN.
module linear_network_collect_seq
    import linear_network_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4,
    parameter int ID_WIDTH   = id_width(NUM_NODE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_en,
    input  logic [NUM_NODE-1:0]            i_valid,
    input  logic [NUM_NODE*DATA_WIDTH-1:0] i_data_bus,
    output logic [NUM_NODE-1:0]            o_ready,
    output logic                           o_valid,
    output logic [DATA_WIDTH-1:0]          o_data_bus,
    output logic [ID_WIDTH-1:0]            o_src_id,
    input  logic                           i_ready
);

    logic [NUM_NODE-1:0]   v_s;
    logic [NUM_NODE-1:0]   take_s;
    logic [DATA_WIDTH-1:0] d_s  [NUM_NODE];
    logic [ID_WIDTH-1:0]   id_s [NUM_NODE];
    logic                  en_s;

    // Qualifying injection with rst_n keeps every o_ready low while reset is held.
    assign en_s      = i_en & rst_n;
    assign take_s[0] = i_ready;

    for (genvar k = 0; k < NUM_NODE; k++) begin : g_stage
        logic                  up_valid_s;
        logic [DATA_WIDTH-1:0] up_data_s;
        logic [ID_WIDTH-1:0]   up_id_s;
        logic                  up_take_s;

        if (k == NUM_NODE - 1) begin : g_last
            logic unused_take_s;
            assign up_valid_s    = 1'b0;
            assign up_data_s     = {DATA_WIDTH{DUMMY_DATA}};
            assign up_id_s       = {ID_WIDTH{1'b0}};
            assign unused_take_s = up_take_s;
        end else begin : g_mid
            assign up_valid_s  = v_s[k+1];
            assign up_data_s   = d_s[k+1];
            assign up_id_s     = id_s[k+1];
            assign take_s[k+1] = up_take_s;
        end

        linear_collect_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .STAGE_ID   (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en_s),
            .loc_valid (i_valid[k]),
            .loc_data  (i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
            .up_valid  (up_valid_s),
            .up_data   (up_data_s),
            .up_id     (up_id_s),
            .dn_take   (take_s[k]),
            .valid     (v_s[k]),
            .data      (d_s[k]),
            .id        (id_s[k]),
            .up_take   (up_take_s),
            .loc_ready (o_ready[k])
        );
    end

    assign o_valid = v_s[0];

    // Sink word and tag read as zero whenever the head slot is empty.
    always_comb begin
        o_data_bus = {DATA_WIDTH{DUMMY_DATA}};
        o_src_id   = {ID_WIDTH{1'b0}};
        if (v_s[0]) begin
            o_data_bus = d_s[0];
            o_src_id   = id_s[0];
        end else begin
            o_data_bus = {DATA_WIDTH{DUMMY_DATA}};
            o_src_id   = {ID_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_linear_network_collect_seq.sv
// Scoreboard bench for linear_network_collect_seq: directed vectors push expected sink words, a monitor pops them.
module tb_linear_network_collect_seq;

    localparam int DW = 32;
    localparam int NN = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_en;
    logic [NN-1:0]    i_valid;
    logic [NN*DW-1:0] i_data_bus;
    logic [NN-1:0]    o_ready;
    logic             o_valid;
    logic [DW-1:0]    o_data_bus;
    logic [IW-1:0]    o_src_id;
    logic             i_ready;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } item_t;

    item_t exp_q[$];
    int    pass_cnt = 0;
    int    chk_cnt  = 0;

    linear_network_collect_seq #(
        .DATA_WIDTH (DW),
        .NUM_NODE   (NN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_src_id   (o_src_id),
        .i_ready    (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] exp_id(input int k);
        logic [IW-1:0] r;
        r = IW'(k);
`ifndef LINEAR_NETWORK_SRC_ID_EN
        r = {IW{1'b0}};
`endif
        return r;
    endfunction

    task automatic push(input logic [DW-1:0] d, input int k);
        item_t it;
        it.data = d;
        it.id   = exp_id(k);
        exp_q.push_back(it);
    endtask

    task automatic set_data(input int k, input logic [DW-1:0] d);
        i_data_bus[k*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every sink transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("sink_unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
                item_t e;
                e = exp_q.pop_front();
                check("sink_word", 64'({o_data_bus, o_src_id}), 64'({e.data, e.id}));
            end
        end else if (rst_n && !o_valid) begin
            check("sink_idle_zero", 64'({o_data_bus, o_src_id}), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n3;
        int nb;
        int cyc;
        int first_wait;
        int b_pres;
        logic seen;

        // Reset with random inputs
        rst_n      = 1'b0;
        i_en       = 1'($urandom);
        i_valid    = 4'($urandom);
        i_ready    = 1'($urandom);
        i_data_bus = {$urandom, $urandom, $urandom, $urandom};
        #2;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data", 64'(o_data_bus), 64'd0);
        check("rst_o_src_id", 64'(o_src_id), 64'd0);
        check("rst_o_ready_rand", 64'(o_ready), 64'd0);
        i_en    = 1'b1;
        i_valid = 4'hF;
        #1;
        check("rst_o_ready_all_req", 64'(o_ready), 64'd0);
        i_valid    = 4'h0;
        i_data_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_en    = 1'b1;
        i_ready = 1'b1;
        tick();

        // Single inject from node 3: visible after 4 edges, for one cycle
        push(32'hAAAA_AAAA, 3);
        i_valid[3] = 1'b1;
        set_data(3, 32'hAAAA_AAAA);
        @(negedge clk);
        check("lat_ready3", 64'(o_ready), 64'h8);
        tick();
        i_valid = 4'h0;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            check($sformatf("lat_valid_e%0d", e), 64'(o_valid), (e == 4) ? 64'd1 : 64'd0);
            @(posedge clk);
        end
        #1;

        // Backpressure: four words held, then drained in order
        for (int k = 0; k < NN; k++) begin
            push(32'(k), k);
            set_data(k, 32'(k));
        end
        i_ready = 1'b0;
        i_valid = 4'hF;
        @(negedge clk);
        check("bp_accept_all", 64'(o_ready), 64'hF);
        tick();
        @(negedge clk);
        check("bp_ready_full1", 64'(o_ready), 64'h0);
        tick();
        @(negedge clk);
        check("bp_ready_full2", 64'(o_ready), 64'h0);
        check("bp_hold_valid", 64'(o_valid), 64'd1);
        tick();
        i_valid = 4'h0;
        i_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_drain_valid_c%0d", c), 64'(o_valid), (c < 4) ? 64'd1 : 64'd0);
            tick();
        end

        // Fairness: node 3 streams 8 words, node 1 contends for 3 words
        push(32'h3000_0000, 3);
        push(32'h3000_0001, 3);
        push(32'hBBBB_BBBB, 1);
        push(32'h3000_0002, 3);
        push(32'hBBBB_BBBB, 1);
        push(32'h3000_0003, 3);
        push(32'hBBBB_BBBB, 1);
        push(32'h3000_0004, 3);
        push(32'h3000_0005, 3);
        push(32'h3000_0006, 3);
        push(32'h3000_0007, 3);
        n3 = 0;
        nb = 0;
        cyc = 0;
        first_wait = -1;
        b_pres = 0;
        while ((n3 < 8 || nb < 3) && cyc < 40) begin
            i_valid = 4'h0;
            if (n3 < 8) begin
                i_valid[3] = 1'b1;
                set_data(3, 32'h3000_0000 + 32'(n3));
            end
            if (cyc >= 3 && nb < 3) begin
                i_valid[1] = 1'b1;
                set_data(1, 32'hBBBB_BBBB);
            end
            @(negedge clk);
            if (i_valid[1]) begin
                b_pres++;
                if (o_ready[1]) begin
                    if (nb == 0) first_wait = b_pres;
                    nb++;
                end
            end
            if (i_valid[3] && o_ready[3]) n3++;
            tick();
            cyc++;
        end
        i_valid = 4'h0;
        check("fair_first_wait", 64'(first_wait), 64'd2);
        check("fair_loop_cycles", 64'(cyc), 64'd11);
        repeat (6) tick();

        // i_en gating: buffered words drain while injection is blocked
        push(32'h5000_0000, 0);
        push(32'h5000_0002, 2);
        i_ready = 1'b0;
        i_en    = 1'b1;
        i_valid = 4'b0101;
        set_data(0, 32'h5000_0000);
        set_data(2, 32'h5000_0002);
        @(negedge clk);
        check("en_fill_ready", 64'(o_ready), 64'h5);
        tick();
        i_en    = 1'b0;
        i_valid = 4'hF;
        for (int k = 0; k < NN; k++) set_data(k, 32'hDEAD_0000 + 32'(k));
        @(negedge clk);
        check("en_off_hold_ready", 64'(o_ready), 64'h0);
        tick();
        i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("en_off_drain_ready_c%0d", c), 64'(o_ready), 64'h0);
            tick();
        end
        for (int k = 0; k < NN; k++) begin
            push(32'h7000_0000 + 32'(k), k);
            set_data(k, 32'h7000_0000 + 32'(k));
        end
        i_en = 1'b1;
        @(negedge clk);
        check("en_resume_ready", 64'(o_ready), 64'hF);
        tick();
        i_valid = 4'h0;
        repeat (6) tick();

        // Reset mid-stream with three buffered words
        i_ready = 1'b0;
        i_valid = 4'b0111;
        for (int k = 0; k < 3; k++) set_data(k, 32'h9000_0000 + 32'(k));
        @(negedge clk);
        check("mrst_accept", 64'(o_ready), 64'h7);
        tick();
        i_valid = 4'h0;
        @(negedge clk);
        check("mrst_buffered", 64'(o_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_valid_drop", 64'(o_valid), 64'd0);
        check("mrst_data_zero", 64'(o_data_bus), 64'd0);
        tick();
        tick();
        rst_n   = 1'b1;
        i_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | o_valid;
            tick();
        end
        check("mrst_no_stale", 64'(seen), 64'd0);
        push(32'hC000_0002, 2);
        i_valid = 4'b0100;
        set_data(2, 32'hC000_0002);
        @(negedge clk);
        check("mrst_post_accept", 64'(o_ready), 64'h4);
        tick();
        i_valid = 4'h0;
        repeat (6) tick();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
